// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
//   Shared types and constants for the AD9228 sample-FIFO drain logic.
//   - drain_state_t : drain scheduler FSM states
//   - ch_width()    : width of a channel index for a given channel count
//   - DEF_*         : default parameter values used by the drain blocks
// -----------------------------------------------------------------------------
package adc_pkg;

  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_DATA_WIDTH   = 12;
  localparam int DEF_BURST_LEN    = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    OUTPUT  = 3'd4
  } drain_state_t;

  // Channel index width; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CH_W = ch_width(DEF_NUM_CHANNELS);

endpackage

// File: rtl/rr_next_ch.sv
// -----------------------------------------------------------------------------
// rr_next_ch
//   Combinational round-robin search: returns the nearest unmasked channel
//   strictly after ptr, wrapping around. ptr itself is the last candidate, so
//   a single unmasked channel selects itself.
//   Ports:
//     ptr     in   current channel
//     mask    in   1 = channel eligible
//     next_ch out  next eligible channel (ptr when none)
//     found   out  at least one channel is eligible
// -----------------------------------------------------------------------------
module rr_next_ch
  import adc_pkg::*;
#(
  parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
  localparam int CH_W         = ch_width(NUM_CHANNELS)
) (
  input  logic [CH_W-1:0]         ptr,
  input  logic [NUM_CHANNELS-1:0] mask,
  output logic [CH_W-1:0]         next_ch,
  output logic                    found
);

  // Scan from the farthest candidate down to the nearest so the nearest hit wins.
  always_comb begin : search
    int   idx;
    logic hit;
    idx     = 0;
    hit     = 1'b0;
    next_ch = ptr;
    found   = 1'b0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      idx     = (int'(ptr) + i) % NUM_CHANNELS;
      hit     = mask[idx];
      next_ch = hit ? CH_W'(idx) : next_ch;
      found   = found | hit;
    end
  end

endmodule

// File: rtl/adc_fifo_drain_sched.sv
// -----------------------------------------------------------------------------
// adc_fifo_drain_sched
//   Round-robin drain of the per-channel ADC sample FIFOs through the shared
//   addressed read mux, emitting channel-tagged samples on a valid/ready
//   stream. Also gates the capture enable and keeps sticky overflow flags.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     enable          run/stop for capture and drain
//     ch_mask         1 = channel takes part in arbitration
//     ovf_clr         pulse, clears all overflow flags (a new overflow wins)
//     read_en         registered copy of enable for the capture block
//     fifo_addr       read mux select
//     fifo_rd_en      one-hot read strobe
//     fifo_not_empty  muxed not-empty flag of fifo_addr
//     fifo_full       muxed full flag of fifo_addr
//     fifo_dout       muxed data, valid one cycle after its read strobe
//     m_valid/m_ready output handshake
//     m_chan, m_data  channel tag and sample
//     ovf_flags       sticky per-channel overflow
//     word_count      words delivered since reset (wraps)
// -----------------------------------------------------------------------------
module adc_fifo_drain_sched
  import adc_pkg::*;
#(
  parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int BURST_LEN    = DEF_BURST_LEN,
  localparam int CH_W         = ch_width(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] ch_mask,
  input  logic                    ovf_clr,
  output logic                    read_en,
  output logic [CH_W-1:0]         fifo_addr,
  output logic [NUM_CHANNELS-1:0] fifo_rd_en,
  input  logic                    fifo_not_empty,
  input  logic                    fifo_full,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CH_W-1:0]         m_chan,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [NUM_CHANNELS-1:0] ovf_flags,
  output logic [31:0]             word_count
);

  localparam logic [NUM_CHANNELS-1:0] CH_ONE = NUM_CHANNELS'(1);

  drain_state_t            state;
  logic [CH_W-1:0]         ptr;
  logic [7:0]              burst_cnt;

  logic [CH_W-1:0]         next_ch;
  logic                    any_unmasked;
  logic [CH_W-1:0]         start_ch;
  logic [NUM_CHANNELS-1:0] ch_onehot;
  logic [NUM_CHANNELS-1:0] ovf_set;
  logic                    burst_last;

  rr_next_ch #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_rr_next_ch (
    .ptr     (ptr),
    .mask    (ch_mask),
    .next_ch (next_ch),
    .found   (any_unmasked)
  );

  // Pointer decode, overflow capture and burst-end detection.
  always_comb begin
    // Leaving IDLE resumes at ptr itself when it is still unmasked.
    start_ch   = ch_mask[ptr] ? ptr : next_ch;
    ch_onehot  = CH_ONE << ptr;
    burst_last = ({1'b0, burst_cnt} + 9'd1) >= 9'(BURST_LEN);
    if ((state == SELECT) && fifo_full) begin
      ovf_set = ch_onehot;
    end else begin
      ovf_set = '0;
    end
  end

  // Drain FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      burst_cnt  <= 8'd0;
      read_en    <= 1'b0;
      fifo_addr  <= '0;
      fifo_rd_en <= '0;
      m_valid    <= 1'b0;
      m_chan     <= '0;
      m_data     <= '0;
      ovf_flags  <= '0;
      word_count <= 32'd0;
    end else begin
      read_en    <= enable;
      fifo_rd_en <= '0;
      // Clear first, then OR in this cycle's overflow so a coincident set survives.
      ovf_flags  <= (ovf_clr ? '0 : ovf_flags) | ovf_set;

      case (state)
        IDLE: begin
          if (enable && any_unmasked) begin
            ptr       <= start_ch;
            fifo_addr <= start_ch;
            state     <= SELECT;
          end else begin
            state <= IDLE;
          end
        end

        // fifo_addr has been stable for a cycle, so the muxed flags belong to ptr.
        SELECT: begin
          if (!enable || !any_unmasked) begin
            state <= IDLE;
          end else if (!ch_mask[ptr] || !fifo_not_empty) begin
            ptr       <= next_ch;
            fifo_addr <= next_ch;
            burst_cnt <= 8'd0;
            state     <= SELECT;
          end else begin
            fifo_rd_en <= ch_onehot;
            state      <= READ;
          end
        end

        // Read strobe is high during this cycle; data arrives in CAPTURE.
        READ: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          m_data  <= fifo_dout;
          m_chan  <= ptr;
          m_valid <= 1'b1;
          state   <= OUTPUT;
        end

        OUTPUT: begin
          if (m_ready) begin
            m_valid    <= 1'b0;
            word_count <= word_count + 32'd1;
            if (burst_last) begin
              ptr       <= next_ch;
              fifo_addr <= next_ch;
              burst_cnt <= 8'd0;
            end else begin
              burst_cnt <= burst_cnt + 8'd1;
            end
            state <= enable ? SELECT : IDLE;
          end else begin
            state <= OUTPUT;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_fifo_drain_sched.sv
// -----------------------------------------------------------------------------
// tb_adc_fifo_drain_sched
//   Directed bench: four behavioural standard (non-FWFT) FIFOs behind the
//   addressed mux, an output logger, and hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_adc_fifo_drain_sched;

  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [NCH-1:0] ch_mask = 4'hF;
  logic           ovf_clr = 1'b0;
  logic           m_ready = 1'b1;
  logic           read_en;
  logic [CW-1:0]  fifo_addr;
  logic [NCH-1:0] fifo_rd_en;
  logic           fifo_not_empty;
  logic           fifo_full;
  logic [DW-1:0]  fifo_dout = 12'h000;
  logic           m_valid;
  logic [CW-1:0]  m_chan;
  logic [DW-1:0]  m_data;
  logic [NCH-1:0] ovf_flags;
  logic [31:0]    word_count;

  // FIFO model state: wrp written only by the stimulus, rdp only by the model.
  logic [DW-1:0]  mem [NCH][16];
  int             wrp [NCH];
  int             rdp [NCH];
  int             rd_seen [NCH];
  logic [NCH-1:0] full_force = 4'h0;
  int             viol = 0;

  // Output log.
  int             n_log = 0;
  logic [CW-1:0]  log_ch  [64];
  logic [DW-1:0]  log_dat [64];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign fifo_not_empty = (wrp[fifo_addr] != rdp[fifo_addr]);
  assign fifo_full      = full_force[fifo_addr];

  adc_fifo_drain_sched #(
    .NUM_CHANNELS (NCH),
    .DATA_WIDTH   (DW),
    .BURST_LEN    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .ch_mask        (ch_mask),
    .ovf_clr        (ovf_clr),
    .read_en        (read_en),
    .fifo_addr      (fifo_addr),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_not_empty (fifo_not_empty),
    .fifo_full      (fifo_full),
    .fifo_dout      (fifo_dout),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_chan         (m_chan),
    .m_data         (m_data),
    .ovf_flags      (ovf_flags),
    .word_count     (word_count)
  );

  // FIFO read side, protocol watch and output logging.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        rdp[i]     <= 0;
        rd_seen[i] <= 0;
      end
      n_log <= 0;
    end else begin
      if ($countones(fifo_rd_en) > 1) viol <= viol + 1;
      for (int i = 0; i < NCH; i++) begin
        if (fifo_rd_en[i]) begin
          rd_seen[i] <= rd_seen[i] + 1;
          if (wrp[i] != rdp[i]) begin
            fifo_dout <= mem[i][rdp[i]];
            rdp[i]    <= rdp[i] + 1;
          end else begin
            viol <= viol + 1;
          end
        end
      end
      if (m_valid && m_ready && n_log < 64) begin
        log_ch[n_log]  <= m_chan;
        log_dat[n_log] <= m_data;
        n_log          <= n_log + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [DW-1:0] val);
    mem[ch][wrp[ch]] = val;
    wrp[ch]++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    ovf_clr    = 1'b0;
    m_ready    = 1'b1;
    ch_mask    = 4'hF;
    full_force = 4'h0;
    for (int i = 0; i < NCH; i++) wrp[i] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_valid && k < max);
  endtask

  task automatic wait_rd(input int max);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (fifo_rd_en == 4'h0 && k < max);
  endtask

  task automatic wait_log(input int target, input int max);
    int k;
    k = 0;
    while (n_log < target && k < max) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    int e;
    int cnt;
    int r0;
    logic stable;

    for (int i = 0; i < NCH; i++) wrp[i] = 0;

    // Reset values.
    do_reset();
    check_val("rst_read_en",    read_en,    32'd0);
    check_val("rst_fifo_addr",  fifo_addr,  32'd0);
    check_val("rst_fifo_rd_en", fifo_rd_en, 32'd0);
    check_val("rst_m_valid",    m_valid,    32'd0);
    check_val("rst_m_chan",     m_chan,     32'd0);
    check_val("rst_m_data",     m_data,     32'd0);
    check_val("rst_ovf",        ovf_flags,  32'd0);
    check_val("rst_wcnt",       word_count, 32'd0);

    // Single channel, three words: first valid in cycle 4, then every 4 cycles.
    do_reset();
    push(0, 12'h111);
    push(0, 12'h222);
    push(0, 12'h333);
    enable = 1'b1;
    wait_valid(20, k);
    check_val("t1_latency", k, 32'd4);
    check_val("t1_chan0",   m_chan, 32'd0);
    check_val("t1_data0",   m_data, 32'h111);
    wait_valid(20, k);
    check_val("t1_gap1",    k, 32'd4);
    check_val("t1_data1",   m_data, 32'h222);
    wait_valid(20, k);
    check_val("t1_gap2",    k, 32'd4);
    check_val("t1_data2",   m_data, 32'h333);
    @(negedge clk);
    check_val("t1_wcnt",    word_count, 32'd3);
    check_val("t1_valid_lo", m_valid, 32'd0);
    check_val("t1_read_en", read_en, 32'd1);
    repeat (12) @(negedge clk);
    check_val("t1_wcnt_hold", word_count, 32'd3);
    check_val("t1_rd_ch0",  rd_seen[0], 32'd3);

    // Four channels x 6 words with bursts of 4.
    do_reset();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 6; i++) push(c, 12'(c * 256 + 16 + i));
    enable = 1'b1;
    wait_log(24, 400);
    check_val("t2_count", n_log, 32'd24);
    e = 0;
    for (int rnd = 0; rnd < 2; rnd++) begin
      cnt = (rnd == 0) ? 4 : 2;
      for (int c = 0; c < NCH; c++) begin
        for (int j = 0; j < cnt; j++) begin
          check_val($sformatf("t2_ch%0d", e),  log_ch[e],  c);
          check_val($sformatf("t2_dat%0d", e), log_dat[e], c * 256 + 16 + rnd * 4 + j);
          e++;
        end
      end
    end

    // Mask 0101: only channels 0 and 2 are ever read.
    do_reset();
    ch_mask = 4'b0101;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 3; i++) push(c, 12'(c * 256 + i));
    enable = 1'b1;
    repeat (120) @(negedge clk);
    check_val("t3_count", n_log, 32'd6);
    check_val("t3_rd1",   rd_seen[1], 32'd0);
    check_val("t3_rd3",   rd_seen[3], 32'd0);
    check_val("t3_rd0",   rd_seen[0], 32'd3);
    check_val("t3_rd2",   rd_seen[2], 32'd3);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("t3_ch%0d", i), log_ch[i], (i < 3) ? 32'd0 : 32'd2);

    // Backpressure: output held, no further reads, exactly one word on release.
    do_reset();
    m_ready = 1'b0;
    push(1, 12'hA5A);
    push(1, 12'h5A5);
    enable = 1'b1;
    wait_valid(20, k);
    check_val("t4_valid", m_valid, 32'd1);
    check_val("t4_chan",  m_chan,  32'd1);
    check_val("t4_data",  m_data,  32'hA5A);
    r0 = rd_seen[1];
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (m_data !== 12'hA5A || m_chan !== 2'd1 || m_valid !== 1'b1) stable = 1'b0;
    end
    check_val("t4_stable",  stable, 32'd1);
    check_val("t4_no_read", rd_seen[1], r0);
    check_val("t4_log0",    n_log, 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_val("t4_log1", n_log, 32'd1);
    repeat (10) @(negedge clk);
    check_val("t4_log1_hold", n_log, 32'd1);
    check_val("t4_data2",     m_data, 32'h5A5);
    check_val("t4_wcnt",      word_count, 32'd1);

    // Overflow flags: set, set beats clear, clear alone.
    do_reset();
    enable = 1'b1;
    full_force = 4'b0100;
    repeat (10) @(negedge clk);
    check_val("t5_ovf_set", ovf_flags, 32'h4);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (fifo_addr != 2'd2 && k < 20);
    check_val("t5_addr2", fifo_addr, 32'd2);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_val("t5_set_wins", ovf_flags, 32'h4);
    full_force = 4'b0000;
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_val("t5_cleared", ovf_flags, 32'h0);

    // Reset asserted while READ on channel 2, after one word was delivered.
    do_reset();
    for (int i = 0; i < 3; i++) push(2, 12'(12'h2C0 + i));
    enable = 1'b1;
    wait_valid(30, k);
    check_val("t6_data0", m_data, 32'h2C0);
    wait_rd(20);
    check_val("t6_in_read", fifo_rd_en, 32'h4);
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_rd_en",  fifo_rd_en, 32'd0);
    check_val("t6_valid",  m_valid,    32'd0);
    check_val("t6_readen", read_en,    32'd0);
    check_val("t6_addr",   fifo_addr,  32'd0);
    check_val("t6_chan",   m_chan,     32'd0);
    check_val("t6_data",   m_data,     32'd0);
    check_val("t6_wcnt",   word_count, 32'd0);
    rst = 1'b0;

    // Enable dropped in CAPTURE: word completes, then no more reads.
    do_reset();
    push(0, 12'h7A1);
    push(0, 12'h7A2);
    push(0, 12'h7A3);
    enable = 1'b1;
    wait_rd(20);
    check_val("t7_in_read", fifo_rd_en, 32'h1);
    @(negedge clk);
    enable = 1'b0;
    wait_valid(10, k);
    check_val("t7_valid", m_valid, 32'd1);
    check_val("t7_data",  m_data,  32'h7A1);
    @(negedge clk);
    check_val("t7_log",   n_log, 32'd1);
    repeat (20) @(negedge clk);
    check_val("t7_no_read", rd_seen[0], 32'd1);
    check_val("t7_wcnt",    word_count, 32'd1);
    check_val("t7_readen",  read_en, 32'd0);
    check_val("t7_idle_valid", m_valid, 32'd0);

    // Read strobes never hit an empty FIFO and are never multi-hot.
    check_val("protocol_viol", viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_fifo_drain_sched.md
Name: adc_fifo_drain_sched

Overview:
- Single-clock round-robin scheduler that drains the per-channel AD9228 sample FIFOs through the shared addressed read mux (fifo_addr / fifo_rd_en / fifo_dout) and emits channel-tagged samples on a valid/ready output stream.
- Sits between the multi-channel ADC capture block and the downstream packetiser/IPIF.
- Also gates the capture block's read_en and latches per-channel FIFO overflow flags.

Parameters:
- NUM_CHANNELS, 4, number of ADC channels/FIFOs (2..16).
- DATA_WIDTH, 12, sample width.
- BURST_LEN, 4, maximum words drained from one channel per grant (1..255).

Ports:
- clk  in  1  system clock; the capture FIFOs' fifo_rd_clk is tied to this clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run/stop for capture and drain.
- ch_mask  in  NUM_CHANNELS  1 = channel participates in arbitration.
- ovf_clr  in  1  pulse; clears all overflow flags.
- read_en  out  1  capture enable to the ADC read block.
- fifo_addr  out  $clog2(NUM_CHANNELS)  mux select.
- fifo_rd_en  out  NUM_CHANNELS  one-hot read strobe.
- fifo_not_empty  in  1  muxed flag for fifo_addr.
- fifo_full  in  1  muxed flag for fifo_addr.
- fifo_dout  in  DATA_WIDTH  muxed data; valid 1 cycle after its rd_en (standard, non-FWFT).
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accept.
- m_chan  out  $clog2(NUM_CHANNELS)  channel tag of m_data.
- m_data  out  DATA_WIDTH  sample.
- ovf_flags  out  NUM_CHANNELS  sticky overflow, one bit per channel.
- word_count  out  32  words delivered since reset; wraps at 2^32.

Behaviour:
- Reset values: read_en=0, fifo_addr=0, fifo_rd_en=0, m_valid=0, m_chan=0, m_data=0, ovf_flags=0, word_count=0, state=IDLE, ptr=0, burst_cnt=0.
- read_en is a registered copy of enable: 1-cycle delay, independent of the drain FSM.
- FSM state IDLE:
  - If enable and ch_mask≠0: set ptr to the first unmasked channel at or after ptr, drive fifo_addr=ptr, go to SELECT.
  - Otherwise stay in IDLE.
- FSM state SELECT:
  - fifo_addr is already stable, so the muxed flags refer to ptr.
  - If fifo_full=1: set ovf_flags[ptr].
  - If ptr is masked, or fifo_not_empty=0: advance ptr to the next unmasked channel (cyclic), clear burst_cnt, stay in SELECT. If enable=0 or ch_mask=0, go to IDLE instead.
  - Otherwise go to READ.
- FSM state READ: fifo_rd_en[ptr]=1 for exactly one cycle; go to CAPTURE.
- FSM state CAPTURE:
  - Latch m_data=fifo_dout and m_chan=ptr.
  - Set m_valid=1 (visible the next cycle); go to OUTPUT.
- FSM state OUTPUT:
  - Hold m_valid, m_data and m_chan stable until m_ready=1.
  - On the handshake: m_valid←0, word_count++, burst_cnt++.
  - If burst_cnt+1<BURST_LEN: keep ptr. Otherwise advance ptr and clear burst_cnt.
  - Next state is SELECT if enable, else IDLE.
- Latency: enable rises in cycle 0 with the channel non-empty → m_valid=1 in cycle 4. Steady-state throughput is 1 word per 4 cycles at m_ready=1.
- fifo_rd_en is never asserted for a FIFO whose not_empty was sampled 0, and never more than one bit at a time.
- enable deasserted mid-transfer: the current word completes (READ→CAPTURE→OUTPUT→handshake), then IDLE. No word read from a FIFO is ever dropped except by rst.
- ch_mask change: takes effect at the next pointer advance. A word already in flight completes.
- Masking the current ptr while in SELECT: treated as empty, so ptr advances.
- ovf_clr and a new overflow in the same cycle: set wins.
- rst mid-operation: everything returns to reset values immediately. A word already read from a FIFO is lost (acceptable).
- word_count wraps 0xFFFFFFFF→0.

Decomposition:
- Shared package adc_pkg holds:
  - state enum drain_state_t {IDLE, SELECT, READ, CAPTURE, OUTPUT};
  - CH_W = $clog2(NUM_CHANNELS) helper;
  - default DATA_WIDTH / NUM_CHANNELS constants.
- One natural sub-module: rr_next_ch, a combinational search for the next unmasked channel after ptr, reusable by other arbiters.

Test Plan:
- Ch0 FIFO holds 3 words (0x111, 0x222, 0x333), others empty, mask=4'hF, m_ready=1, enable raised in cycle 0:
  - m_valid in cycle 4 with m_chan=0, m_data=0x111;
  - all three delivered in order, 4 cycles apart;
  - word_count=3; the FSM then cycles in SELECT.
- All four channels hold 6 words each, BURST_LEN=4:
  - output channel order is 0×4, 1×4, 2×4, 3×4, then 0×2, 1×2, 2×2, 3×2;
  - 24 words total.
- mask=4'b0101 with all FIFOs non-empty: only channels 0 and 2 are read; fifo_rd_en[1] and fifo_rd_en[3] are never asserted.
- Backpressure: m_ready=0 for 10 cycles during OUTPUT:
  - m_data and m_chan stay stable;
  - no further fifo_rd_en;
  - exactly one word is delivered on release.
- Overflow:
  - hold ch2 fifo_full=1 during SELECT → ovf_flags=4'b0100;
  - ovf_clr pulse coincident with a new full on ch2 → bit stays set;
  - ovf_clr alone → flags go to 0.
- Reset and stop:
  - rst asserted in READ → next cycle all outputs are at reset values and fifo_rd_en=0;
  - enable dropped in CAPTURE → the word still handshakes, then IDLE, with no further reads.
